// File: rtl/axi_lite_arbiter_pkg.sv
// axi_lite_arbiter package: FSM state encoding, AXI response codes and
// fixed protection attribute shared by the arbiter RTL and its bench.
package axil_arb_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WADDR = 3'd1,
      WRESP = 3'd2,
      RADDR = 3'd3,
      RDATA = 3'd4,
      RESP  = 3'd5
   } state_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   // AWPROT/ARPROT are always unprivileged, secure, data
   localparam logic [2:0] PROT_NONE = 3'b000;

endpackage

// File: rtl/axi_lite_arbiter_if.sv
// AXI4-Lite bus bundle: master modport is the arbiter side, slave modport
// is the downstream target side.
interface axi_lite_arbiter_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
);
   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

   logic                  AWVALID;
   logic                  AWREADY;
   logic [ADDR_WIDTH-1:0] AWADDR;
   logic [2:0]            AWPROT;

   logic                  WVALID;
   logic                  WREADY;
   logic [DATA_WIDTH-1:0] WDATA;
   logic [STRB_WIDTH-1:0] WSTRB;

   logic                  BVALID;
   logic                  BREADY;
   logic [1:0]            BRESP;

   logic                  ARVALID;
   logic                  ARREADY;
   logic [ADDR_WIDTH-1:0] ARADDR;
   logic [2:0]            ARPROT;

   logic                  RVALID;
   logic                  RREADY;
   logic [DATA_WIDTH-1:0] RDATA;
   logic [1:0]            RRESP;

   modport master (
      output AWVALID, AWADDR, AWPROT, input AWREADY,
      output WVALID, WDATA, WSTRB, input WREADY,
      input  BVALID, BRESP, output BREADY,
      output ARVALID, ARADDR, ARPROT, input ARREADY,
      input  RVALID, RDATA, RRESP, output RREADY
   );

   modport slave (
      input  AWVALID, AWADDR, AWPROT, output AWREADY,
      input  WVALID, WDATA, WSTRB, output WREADY,
      output BVALID, BRESP, input BREADY,
      input  ARVALID, ARADDR, ARPROT, output ARREADY,
      output RVALID, RDATA, RRESP, input RREADY
   );

endinterface

// File: rtl/axi_lite_arbiter_rr_arbiter.sv
// Combinational requester arbiter. Default is round-robin starting after
// `last`; defining AXIL_ARB_FIXED_PRIO_EN selects fixed priority where the
// lowest index wins and `last` is ignored.
module rr_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned GW      = 2
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [GW-1:0]      last,
   output logic [NUM_REQ-1:0] gnt,
   output logic [GW-1:0]      idx,
   output logic               any
);

   assign any = |req;

`ifdef AXIL_ARB_FIXED_PRIO_EN
   logic unused_last;
   assign unused_last = ^last;

   // Lowest-index requester wins
   always_comb begin
      logic found;
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (!found && req[GW'(i)]) begin
            found        = 1'b1;
            gnt[GW'(i)]  = 1'b1;
            idx          = GW'(i);
         end
      end
   end
`else
   // Search from last+1 upward, wrapping modulo NUM_REQ
   always_comb begin
      logic        found;
      int unsigned j;
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      j     = 0;
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         j = (int'(last) + k) % NUM_REQ;
         if (!found && req[GW'(j)]) begin
            found        = 1'b1;
            gnt[GW'(j)]  = 1'b1;
            idx          = GW'(j);
         end
      end
   end
`endif

endmodule

// File: rtl/axi_lite_arbiter.sv
// AXI4-Lite manager shared by NUM_REQ local requesters, one transaction
// at a time. Arbitration is round-robin unless AXIL_ARB_FIXED_PRIO_EN is
// defined, in which case fixed priority (lowest index) is used.
module axi_lite_arbiter
   import axil_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                            ACLK,
   input  logic                            ARESET,
   input  logic [NUM_REQ-1:0]              req_valid,
   input  logic [NUM_REQ-1:0]              req_write,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
   input  logic [NUM_REQ*DATA_WIDTH/8-1:0] req_wstrb,
   output logic [NUM_REQ-1:0]              req_ready,
   output logic [NUM_REQ-1:0]              rsp_valid,
   output logic [DATA_WIDTH-1:0]           rsp_rdata,
   output logic [1:0]                      rsp_resp,
   axi_lite_arbiter_if.master              bus
);

   localparam int unsigned GW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

   state_e                state_q;
   logic [GW-1:0]         gnt_idx_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [STRB_WIDTH-1:0] wstrb_q;
   logic                  write_q;
   logic                  aw_valid_q;
   logic                  w_valid_q;
   logic                  aw_done_q;
   logic                  w_done_q;
   logic                  b_ready_q;
   logic                  ar_valid_q;
   logic                  r_ready_q;
   logic [NUM_REQ-1:0]    rsp_valid_q;
   logic [DATA_WIDTH-1:0] rsp_rdata_q;
   logic [1:0]            rsp_resp_q;

   logic [NUM_REQ-1:0]    arb_gnt;
   logic [GW-1:0]         arb_idx;
   logic                  arb_any;
   logic [GW-1:0]         arb_last;
   logic                  grant;
   logic                  aw_hs;
   logic                  w_hs;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .GW      (GW)
   ) u_arb (
      .req  (req_valid),
      .last (arb_last),
      .gnt  (arb_gnt),
      .idx  (arb_idx),
      .any  (arb_any)
   );

   assign grant     = (state_q == IDLE) && arb_any;
   assign req_ready = (state_q == IDLE) ? arb_gnt : '0;
   assign aw_hs     = aw_valid_q && bus.AWREADY;
   assign w_hs      = w_valid_q && bus.WREADY;

`ifdef AXIL_ARB_FIXED_PRIO_EN
   assign arb_last = GW'(NUM_REQ - 1);
`else
   logic [GW-1:0] last_q;

   // Remember the most recent grant so the next search starts after it
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         last_q <= GW'(NUM_REQ - 1);
      end else if (grant) begin
         last_q <= arb_idx;
      end
   end

   assign arb_last = last_q;
`endif

   // Transaction FSM with capture registers and registered bus outputs
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q     <= IDLE;
         gnt_idx_q   <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         write_q     <= 1'b0;
         aw_valid_q  <= 1'b0;
         w_valid_q   <= 1'b0;
         aw_done_q   <= 1'b0;
         w_done_q    <= 1'b0;
         b_ready_q   <= 1'b0;
         ar_valid_q  <= 1'b0;
         r_ready_q   <= 1'b0;
         rsp_valid_q <= '0;
         rsp_rdata_q <= '0;
         rsp_resp_q  <= RESP_OKAY;
      end else begin
         rsp_valid_q <= '0;
         case (state_q)
            IDLE: begin
               if (arb_any) begin
                  gnt_idx_q <= arb_idx;
                  addr_q    <= req_addr[int'(arb_idx)*ADDR_WIDTH +: ADDR_WIDTH];
                  wdata_q   <= req_wdata[int'(arb_idx)*DATA_WIDTH +: DATA_WIDTH];
                  wstrb_q   <= req_wstrb[int'(arb_idx)*STRB_WIDTH +: STRB_WIDTH];
                  write_q   <= req_write[arb_idx];
                  if (req_write[arb_idx]) begin
                     aw_valid_q <= 1'b1;
                     w_valid_q  <= 1'b1;
                     state_q    <= WADDR;
                  end else begin
                     ar_valid_q <= 1'b1;
                     state_q    <= RADDR;
                  end
               end
            end
            WADDR: begin
               if (aw_hs) begin
                  aw_valid_q <= 1'b0;
                  aw_done_q  <= 1'b1;
               end
               if (w_hs) begin
                  w_valid_q <= 1'b0;
                  w_done_q  <= 1'b1;
               end
               if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                  aw_done_q <= 1'b0;
                  w_done_q  <= 1'b0;
                  b_ready_q <= 1'b1;
                  state_q   <= WRESP;
               end
            end
            WRESP: begin
               if (bus.BVALID && write_q) begin
                  b_ready_q   <= 1'b0;
                  rsp_resp_q  <= bus.BRESP;
                  rsp_rdata_q <= '0;
                  rsp_valid_q <= NUM_REQ'(1) << gnt_idx_q;
                  state_q     <= RESP;
               end
            end
            RADDR: begin
               if (bus.ARREADY) begin
                  ar_valid_q <= 1'b0;
                  r_ready_q  <= 1'b1;
                  state_q    <= RDATA;
               end
            end
            RDATA: begin
               if (bus.RVALID && !write_q) begin
                  r_ready_q   <= 1'b0;
                  rsp_resp_q  <= bus.RRESP;
                  rsp_rdata_q <= bus.RDATA;
                  rsp_valid_q <= NUM_REQ'(1) << gnt_idx_q;
                  state_q     <= RESP;
               end
            end
            RESP: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Bus and requester-side outputs straight from registers
   assign bus.AWVALID = aw_valid_q;
   assign bus.AWADDR  = addr_q;
   assign bus.AWPROT  = PROT_NONE;
   assign bus.WVALID  = w_valid_q;
   assign bus.WDATA   = wdata_q;
   assign bus.WSTRB   = wstrb_q;
   assign bus.BREADY  = b_ready_q;
   assign bus.ARVALID = ar_valid_q;
   assign bus.ARADDR  = addr_q;
   assign bus.ARPROT  = PROT_NONE;
   assign bus.RREADY  = r_ready_q;

   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_resp  = rsp_resp_q;

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Bench for axi_lite_arbiter: directed requester stimulus, a delay-programmable
// AXI4-Lite slave, and a response scoreboard. Honours AXIL_ARB_FIXED_PRIO_EN.
module tb_axi_lite_arbiter;
   import axil_arb_pkg::*;

   localparam int unsigned N  = 4;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;

   logic            ACLK;
   logic            ARESET;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_write;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_wdata;
   logic [N*4-1:0]  req_wstrb;
   logic [N-1:0]    req_ready;
   logic [N-1:0]    rsp_valid;
   logic [DW-1:0]   rsp_rdata;
   logic [1:0]      rsp_resp;

   axi_lite_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   axi_lite_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .ACLK      (ACLK),
      .ARESET    (ARESET),
      .req_valid (req_valid),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_wstrb (req_wstrb),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_rdata (rsp_rdata),
      .rsp_resp  (rsp_resp),
      .bus       (bus)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int          idx;
      logic [31:0] rdata;
      logic [1:0]  resp;
   } rsp_t;

   rsp_t sb[$];
   int   grant_q[$];

   // slave programming (written by the main sequence only)
   int          aw_delay = 0;
   int          w_delay  = 0;
   int          b_delay  = 0;
   int          ar_delay = 0;
   int          r_delay  = 0;
   logic [1:0]  b_resp   = RESP_OKAY;
   logic [31:0] r_data   = 32'h0;
   logic [1:0]  r_resp   = RESP_OKAY;

   // slave statistics (written by the slave only)
   int w_beats = 0;
   int b_beats = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // AXI4-Lite slave with per-channel programmable wait states
   initial begin
      int   aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
      logic aw_got, w_got, b_pend, r_pend;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
      aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
      bus.AWREADY = 0; bus.WREADY = 0; bus.ARREADY = 0;
      bus.BVALID = 0; bus.BRESP = 0; bus.RVALID = 0; bus.RDATA = 0; bus.RRESP = 0;
      forever begin
         @(posedge ACLK);
         if (ARESET) begin
            aw_got = 0; w_got = 0; b_pend = 0; r_pend = 0;
         end else begin
            if (bus.WVALID && bus.WREADY) begin w_beats++; w_got = 1; end
            if (bus.AWVALID && bus.AWREADY) aw_got = 1;
            if (bus.BVALID && bus.BREADY) begin b_beats++; b_pend = 0; end
            if (bus.RVALID && bus.RREADY) r_pend = 0;
            if (aw_got && w_got) begin aw_got = 0; w_got = 0; b_pend = 1; b_cnt = 0; end
            if (bus.ARVALID && bus.ARREADY) begin r_pend = 1; r_cnt = 0; end
         end
         @(negedge ACLK);
         if (bus.AWVALID && !ARESET) begin
            if (aw_cnt >= aw_delay) bus.AWREADY = 1; else begin bus.AWREADY = 0; aw_cnt++; end
         end else begin bus.AWREADY = 0; aw_cnt = 0; end
         if (bus.WVALID && !ARESET) begin
            if (w_cnt >= w_delay) bus.WREADY = 1; else begin bus.WREADY = 0; w_cnt++; end
         end else begin bus.WREADY = 0; w_cnt = 0; end
         if (bus.ARVALID && !ARESET) begin
            if (ar_cnt >= ar_delay) bus.ARREADY = 1; else begin bus.ARREADY = 0; ar_cnt++; end
         end else begin bus.ARREADY = 0; ar_cnt = 0; end
         if (b_pend && !ARESET) begin
            if (b_cnt >= b_delay) begin bus.BVALID = 1; bus.BRESP = b_resp; end
            else begin bus.BVALID = 0; b_cnt++; end
         end else bus.BVALID = 0;
         if (r_pend && !ARESET) begin
            if (r_cnt >= r_delay) begin bus.RVALID = 1; bus.RDATA = r_data; bus.RRESP = r_resp; end
            else begin bus.RVALID = 0; r_cnt++; end
         end else bus.RVALID = 0;
      end
   end

   // Grant recorder and response scoreboard
   initial begin
      forever begin
         @(negedge ACLK);
         for (int i = 0; i < N; i++)
            if (req_ready[i]) grant_q.push_back(i);
         if (rsp_valid !== '0) begin
            if (sb.size() == 0) begin
               check("rsp_unexpected", 64'(rsp_valid), 64'(0));
            end else begin
               rsp_t e;
               logic [N-1:0] oh;
               e  = sb.pop_front();
               oh = '0;
               oh[e.idx] = 1'b1;
               check("rsp_valid", 64'(rsp_valid), 64'(oh));
               check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
               check("rsp_resp", 64'(rsp_resp), 64'(e.resp));
            end
         end
      end
   end

   task automatic expect_rsp(input int idx, input logic [31:0] rdata, input logic [1:0] resp);
      rsp_t e;
      e.idx = idx; e.rdata = rdata; e.resp = resp;
      sb.push_back(e);
   endtask

   // Present one command from requester i and withdraw it right after grant
   task automatic issue(input int i, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] strb);
      logic got;
      got = 0;
      @(posedge ACLK); #1;
      req_write[i]           = wr;
      req_addr[i*AW +: AW]   = addr;
      req_wdata[i*DW +: DW]  = data;
      req_wstrb[i*4 +: 4]    = strb;
      req_valid[i]           = 1'b1;
      for (int n = 0; n < 100; n++) begin
         @(negedge ACLK);
         if (req_ready[i]) begin got = 1; break; end
      end
      check($sformatf("grant_req%0d", i), 64'(got), 64'(1));
      @(posedge ACLK); #1;
      req_valid[i] = 1'b0;
   endtask

   task automatic drain();
      for (int n = 0; n < 200; n++) begin
         if (sb.size() == 0) break;
         @(negedge ACLK);
      end
      check("drain", 64'(sb.size()), 64'(0));
      @(negedge ACLK);
   endtask

   task automatic do_reset();
      @(posedge ACLK); #1;
      ARESET = 1'b1;
      repeat (2) @(posedge ACLK);
      #1 ARESET = 1'b0;
   endtask

   // Directed sequence
   initial begin
      int base, ar_cycles, w0, b0, n_exp;
      int exp_order[5];
      logic seen;

      ARESET = 1'b1;
      req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
      repeat (3) @(posedge ACLK);
      #1 ARESET = 1'b0;
      @(negedge ACLK);
      check("rst_state", 64'(dut.state_q), 64'(IDLE));
      check("rst_valids", 64'({bus.AWVALID, bus.WVALID, bus.BREADY, bus.ARVALID, bus.RREADY}), 64'(0));
      check("rst_rsp", 64'({rsp_valid, req_ready, rsp_resp}), 64'(0));
      check("rst_rdata", 64'(rsp_rdata), 64'(0));

      // single zero-wait write from requester 1
      expect_rsp(1, 32'h0, RESP_OKAY);
      issue(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
      @(negedge ACLK);
      check("c1_awvalid", 64'(bus.AWVALID), 64'(1));
      check("c1_awaddr", 64'(bus.AWADDR), 64'h10);
      check("c1_wvalid", 64'(bus.WVALID), 64'(1));
      check("c1_wdata", 64'(bus.WDATA), 64'hDEADBEEF);
      check("c1_wstrb", 64'(bus.WSTRB), 64'hF);
      @(negedge ACLK);
      check("c2_bready", 64'(bus.BREADY), 64'(1));
      @(negedge ACLK);
      check("c3_rsp_valid", 64'(rsp_valid), 64'b0010);
      @(negedge ACLK);
      check("c4_idle", 64'(dut.state_q), 64'(IDLE));
      check("c4_rsp_low", 64'(rsp_valid), 64'(0));
      drain();

      // read from requester 2 with AR and R wait states, SLVERR
      ar_delay = 3; r_delay = 2; r_data = 32'h12345678; r_resp = RESP_SLVERR;
      expect_rsp(2, 32'h12345678, RESP_SLVERR);
      issue(2, 1'b0, 32'h20, 32'h0, 4'h0);
      ar_cycles = 0;
      for (int n = 0; n < 20; n++) begin
         @(negedge ACLK);
         if (!bus.ARVALID) break;
         ar_cycles++;
         check("ar_addr_stable", 64'(bus.ARADDR), 64'h20);
      end
      check("ar_valid_cycles", 64'(ar_cycles), 64'(4));
      drain();
      ar_delay = 0; r_delay = 0;

      // split W/AW: W accepted two cycles ahead of AW
      w0 = w_beats; b0 = b_beats;
      aw_delay = 2; w_delay = 0;
      expect_rsp(3, 32'h0, RESP_OKAY);
      issue(3, 1'b1, 32'h40, 32'hA5A5_0001, 4'h3);
      @(negedge ACLK);
      check("sp1_aw_w", 64'({bus.AWVALID, bus.WVALID}), 64'b11);
      @(negedge ACLK);
      check("sp2_aw_w", 64'({bus.AWVALID, bus.WVALID}), 64'b10);
      @(negedge ACLK);
      check("sp3_aw_w", 64'({bus.AWVALID, bus.WVALID}), 64'b10);
      @(negedge ACLK);
      check("sp4_bready", 64'({bus.AWVALID, bus.WVALID, bus.BREADY}), 64'b001);
      drain();
      check("sp_w_beats", 64'(w_beats - w0), 64'(1));
      check("sp_b_beats", 64'(b_beats - b0), 64'(1));
      aw_delay = 0;

      // all requesters hold valid from reset
      do_reset();
`ifdef AXIL_ARB_FIXED_PRIO_EN
      n_exp = 3;
      exp_order = '{0, 0, 0, 0, 0};
`else
      n_exp = 5;
      exp_order = '{0, 1, 2, 3, 0};
`endif
      r_data = 32'hCAFE_0000; r_resp = RESP_OKAY;
      for (int k = 0; k < n_exp; k++) expect_rsp(exp_order[k], 32'hCAFE_0000, RESP_OKAY);
      base = grant_q.size();
      @(posedge ACLK); #1;
      req_write = '0;
      req_valid = '1;
      for (int n = 0; n < 200; n++) begin
         @(negedge ACLK); #1;
         if (grant_q.size() - base >= n_exp) break;
      end
      @(posedge ACLK); #1;
      req_valid = '0;
      check("rr_grant_count", 64'(grant_q.size() - base), 64'(n_exp));
      for (int k = 0; k < n_exp; k++)
         if (base + k < grant_q.size())
            check($sformatf("rr_grant%0d", k), 64'(grant_q[base + k]), 64'(exp_order[k]));
      drain();

      // reset while waiting in WRESP
      b_delay = 10;
      issue(1, 1'b1, 32'h80, 32'h1111_2222, 4'hF);
      seen = 0;
      for (int n = 0; n < 20; n++) begin
         @(negedge ACLK);
         if (bus.BREADY) begin seen = 1; break; end
      end
      check("mid_in_wresp", 64'({seen, dut.state_q}), 64'({1'b1, WRESP}));
      @(posedge ACLK); #1;
      ARESET = 1'b1;
      @(posedge ACLK); #1;
      ARESET = 1'b0;
      @(negedge ACLK);
      check("mr_valids", 64'({bus.AWVALID, bus.WVALID, bus.BREADY, bus.ARVALID, bus.RREADY}), 64'(0));
      check("mr_state", 64'(dut.state_q), 64'(IDLE));
      check("mr_rsp", 64'(rsp_valid), 64'(0));
      b_delay = 0;
      r_data = 32'h0BAD_F00D; r_resp = RESP_OKAY;
      expect_rsp(0, 32'h0BAD_F00D, RESP_OKAY);
      @(posedge ACLK); #1;
      req_write = '0;
      req_valid = 4'b0101;
      @(negedge ACLK);
      check("mr_first_grant", 64'(req_ready), 64'b0001);
      @(posedge ACLK); #1;
      req_valid = '0;
      drain();
      repeat (3) @(negedge ACLK);
      check("final_sb_empty", 64'(sb.size()), 64'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
